spram_fifo_ctrl: RTL and testbench

SPRAM_FIFO_CTRL -- requirements
Module: spram_fifo_ctrl

---
 rtl/spram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_spram_fifo_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_fifo_ctrl.sv
// rtl/spram_fifo_ctrl.sv - FIFO controller over an external single-port synchronous RAM (optional SPRAM_FIFO_FLUSH_EN adds a flush input)
module spram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
`ifdef SPRAM_FIFO_FLUSH_EN
    input  logic          flush,
`endif
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  RD_PEND = 1'b1;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

    logic [0:0]    state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   mem_cnt;
    logic          flush_now;
    logic          issue_rd;
    logic          wr_fire;

`ifdef SPRAM_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Port arbitration: a read issue wins the single RAM port; writes take the remaining cycles.
    always_comb begin
        issue_rd = !rst && !flush_now && (state == IDLE) && (mem_cnt != '0)
                   && (!rd_valid || rd_ready);
        wr_ready = !rst && !flush_now && (mem_cnt != DEPTH) && !issue_rd;
        wr_fire  = wr_valid && wr_ready;
        ram_we   = wr_fire;
        ram_din  = wr_data;
        ram_addr = issue_rd ? rptr : wptr;
    end

    // Status: count includes the word in flight from the RAM and the output register.
    always_comb begin
        count = mem_cnt + (AW+1)'(state == RD_PEND) + (AW+1)'(rd_valid);
        full  = (mem_cnt == DEPTH);
        empty = (count == '0);
    end

    // Circular-buffer pointers and RAM occupancy; accept and issue never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            mem_cnt <= '0;
        end else if (flush_now) begin
            wptr    <= '0;
            rptr    <= '0;
            mem_cnt <= '0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + AW'(1);
            end
            if (issue_rd) begin
                rptr <= rptr + AW'(1);
            end
            if (wr_fire) begin
                mem_cnt <= mem_cnt + (AW+1)'(1);
            end else if (issue_rd) begin
                mem_cnt <= mem_cnt - (AW+1)'(1);
            end
        end
    end

    // Read FSM and output register: RD_PEND captures the RAM's registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush_now) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
        end else if (state == RD_PEND) begin
            state    <= IDLE;
            rd_data  <= ram_dout;
            rd_valid <= 1'b1;
        end else begin
            if (issue_rd) begin
                state <= RD_PEND;
            end
            // An issue implies the head was consumed (or absent), so the register empties either way.
            if (issue_rd || rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb/tb_spram_fifo_ctrl.sv - self-checking bench for spram_fifo_ctrl with queue-based reference model
module tb_spram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
`ifdef SPRAM_FIFO_FLUSH_EN
    logic       flush;
`endif
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

    spram_fifo_ctrl #(.DW(8), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
`ifdef SPRAM_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM with registered read data; preloaded with junk.
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hE0 + 8'(i);
        ram_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RAM contents as a queue, one word in flight, one output word.
    logic [7:0] q [$];
    bit         pend;
    logic [7:0] pword;
    bit         outv;
    logic [7:0] outd;
    int         wr_total;
    int         rd_total;

    initial begin
        bit fl, issue, wready, wfire;
        int exp_count;
        q.delete(); pend = 0; outv = 0; outd = 8'h00; pword = 8'h00;
        wr_total = 0; rd_total = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete(); pend = 0; outv = 0; outd = 8'h00;
                wr_total = 0; rd_total = 0;
                chk("m_rst_wr_ready", 32'(wr_ready), 0);
                chk("m_rst_ram_we",   32'(ram_we),   0);
                chk("m_rst_count",    32'(count),    0);
                chk("m_rst_empty",    32'(empty),    1);
                chk("m_rst_full",     32'(full),     0);
                chk("m_rst_rd_valid", 32'(rd_valid), 0);
                chk("m_rst_rd_data",  32'(rd_data),  0);
            end else begin
`ifdef SPRAM_FIFO_FLUSH_EN
                fl = flush;
`else
                fl = 1'b0;
`endif
                issue     = !fl && !pend && (q.size() != 0) && (!outv || rd_ready);
                wready    = !fl && (q.size() != 16) && !issue;
                wfire     = wr_valid && wready;
                exp_count = q.size() + int'(pend) + int'(outv);
                chk("m_wr_ready", 32'(wr_ready), 32'(wready));
                chk("m_ram_we",   32'(ram_we),   32'(wfire));
                chk("m_rd_valid", 32'(rd_valid), 32'(outv));
                chk("m_rd_data",  32'(rd_data),  32'(outd));
                chk("m_count",    32'(count),    32'(exp_count));
                chk("m_empty",    32'(empty),    32'(exp_count == 0));
                chk("m_full",     32'(full),     32'(q.size() == 16));
                if (wfire) begin
                    chk("m_wr_addr", 32'(ram_addr), 32'(wr_total % 16));
                    chk("m_ram_din", 32'(ram_din),  32'(wr_data));
                end else if (issue) begin
                    chk("m_rd_addr", 32'(ram_addr), 32'(rd_total % 16));
                end
                @(posedge clk);
                if (fl) begin
                    q.delete(); pend = 0; outv = 0; wr_total = 0; rd_total = 0;
                end else begin
                    if (pend) begin
                        outd = pword; outv = 1; pend = 0;
                    end else if (outv && rd_ready) begin
                        outv = 0;
                    end
                    if (issue) begin
                        pword = q.pop_front(); pend = 1; rd_total++;
                    end
                    if (wfire) begin
                        q.push_back(wr_data); wr_total++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        wr_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Offer a word until accepted; returns 1 ns after the accepting edge.
    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        #1;
        while (!wr_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("push_ready", 32'(wr_ready), 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, last, cyc, sent, recv;
        bit sent_now;
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h3C; rd_ready = 1'b1;
`ifdef SPRAM_FIFO_FLUSH_EN
        flush = 1'b0;
`endif
        step();
        step();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_ram_we",   32'(ram_we),   0);
        chk("rst_count",    32'(count),    0);
        chk("rst_empty",    32'(empty),    1);
        chk("rst_full",     32'(full),     0);
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        step();

        // Single word: write at address 0, visible two edges after acceptance.
        wr_valid = 1'b1; wr_data = 8'hAA;
        #1;
        chk("w1_ram_we",   32'(ram_we),   1);
        chk("w1_ram_addr", 32'(ram_addr), 0);
        step();
        wr_valid = 1'b0;
        chk("w1_count_e0", 32'(count),    1);
        step();
        chk("w1_pend_valid", 32'(rd_valid), 0);
        chk("w1_pend_count", 32'(count),    1);
        step();
        chk("w1_rd_valid", 32'(rd_valid), 1);
        chk("w1_rd_data",  32'(rd_data),  8'hAA);
        chk("w1_count",    32'(count),    1);

        // Fill: 16 words then a 17th, 18th stalls.
        reset_dut();
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill16_count", 32'(count), 16);
        chk("fill16_full",  32'(full),  0);
        push(8'h10);
        wr_valid = 1'b1; wr_data = 8'h11;
        #1;
        chk("fill_full",     32'(full),     1);
        chk("fill_wr_ready", 32'(wr_ready), 0);
        chk("fill_count",    32'(count),    17);
        step();
        step();
        chk("stall_count",  32'(count),  17);
        chk("stall_ram_we", 32'(ram_we), 0);
        wr_valid = 1'b0;

        // Drain in order at one word per two cycles, pointers wrap.
        rd_ready = 1'b1;
        got = 0; last = 0; cyc = 0;
        while (got < 17 && cyc < 200) begin
            @(negedge clk);
            if (rd_valid) begin
                chk("drain_data", 32'(rd_data), 32'(got));
                if (got > 0) chk("drain_gap", 32'(cyc - last), 2);
                last = cyc;
                got++;
            end
            step();
            cyc++;
        end
        chk("drain_words", 32'(got), 17);
        step();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // Continuous streaming of 40 words.
        sent = 0; recv = 0; cyc = 0;
        wr_valid = 1'b1; wr_data = 8'h20; rd_ready = 1'b1;
        while (recv < 40 && cyc < 400) begin
            @(negedge clk);
            sent_now = wr_valid && wr_ready;
            if (rd_valid && rd_ready) begin
                chk("stream_data", 32'(rd_data), 32'(8'h20 + 8'(recv)));
                recv++;
            end
            step();
            cyc++;
            if (sent_now) begin
                sent++;
                wr_data = 8'h20 + 8'(sent);
                if (sent == 40) wr_valid = 1'b0;
            end
        end
        chk("stream_recv", 32'(recv), 40);
        chk("stream_sent", 32'(sent), 40);
        step();
        chk("stream_empty", 32'(empty), 1);

        // Reset during the in-flight read discards the word.
        reset_dut();
        rd_ready = 1'b0;
        push(8'h77);
        step();
        chk("pend_count", 32'(count), 1);
        rst = 1'b1;
        #1;
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_count",    32'(count),    0);
        chk("arst_empty",    32'(empty),    1);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_rst_rd_valid", 32'(rd_valid), 0);
        chk("post_rst_count",    32'(count),    0);

`ifdef SPRAM_FIFO_FLUSH_EN
        // Flush clears the controller; later traffic is unaffected.
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        chk("pre_flush_count", 32'(count), 5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        push(8'h55);
        cyc = 0;
        while (!rd_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("flush_rd_valid", 32'(rd_valid), 1);
        chk("flush_rd_data",  32'(rd_data),  8'h55);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
